spike_collector: RTL and testbench

- Sits on the NoC at the memory-wrapper address (13) and consumes the 33-bit output-spike packets that every PE's packetizer emits.
- Each PE sends one spike bit per output position. PEs may run ahead of one another, so the block reorders the spikes per PE.
- When every PE has reported output index k, it emits one packed row (one bit per PE) for index k to the output-feature-map writer.
- Malformed or excess packets are dropped and counted.

---
 rtl/spike_collector_if.sv | 27 ++
 rtl/spike_collector.sv | 254 +++++++++++++++++++++++++
 tb/tb_spike_collector.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_collector_if.sv
// Packet and output-row channels between the NoC, the spike collector and
// the output-feature-map writer.
interface spike_collector_if #(
    parameter int PKT_W  = 33,
    parameter int NUM_PE = 5,
    parameter int IDX_W  = 4
);
    logic [PKT_W-1:0]  pkt_data;
    logic              pkt_valid;
    logic              pkt_ready;
    logic [NUM_PE-1:0] out_row;
    logic [IDX_W-1:0]  out_idx;
    logic              out_valid;
    logic              out_ready;

    // Producer of packets / consumer of rows
    modport master (
        output pkt_data, pkt_valid, out_ready,
        input  pkt_ready, out_row, out_idx, out_valid
    );

    // The collector itself
    modport slave (
        input  pkt_data, pkt_valid, out_ready,
        output pkt_ready, out_row, out_idx, out_valid
    );
endinterface

// File: rtl/spike_collector.sv
// Spike collector: accepts per-PE output-spike packets from the NoC, stores
// them per PE in arrival order, and emits one packed row (one bit per PE) for
// each output position once every PE has reported it. Rows leave strictly in
// index order. Malformed or excess packets are dropped and counted.
module spike_collector #(
    parameter int NUM_PE     = 5,
    parameter int OUT_PER_PE = 10,
    parameter int PKT_W      = 33,
    parameter int ADDR_W     = 4,
    parameter int MY_ADDR    = 13,
    parameter int IDX_W      = $clog2(OUT_PER_PE),
    parameter int CNT_W      = $clog2(OUT_PER_PE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    spike_collector_if.slave bus,
    output logic             busy,
    output logic             done,
    output logic             err_drop,
    output logic [7:0]       drop_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                  state_r, state_nxt_s;

    logic [OUT_PER_PE-1:0]   spike_buf_r [NUM_PE];
    logic [OUT_PER_PE-1:0]   buf_nxt_s   [NUM_PE];
    logic [CNT_W-1:0]        wr_cnt_r    [NUM_PE];
    logic [CNT_W-1:0]        cnt_nxt_s   [NUM_PE];
    logic [IDX_W-1:0]        rd_idx_r, rd_idx_nxt_s;

    logic                    out_valid_r, out_valid_nxt_s;
    logic [NUM_PE-1:0]       out_row_r, out_row_nxt_s;
    logic [IDX_W-1:0]        out_idx_r, out_idx_nxt_s;
    logic                    pkt_ready_r, busy_r, done_r;
    logic                    err_drop_r, err_drop_nxt_s;
    logic [7:0]              drop_count_r, drop_count_nxt_s;

    logic                    pkt_type_s, spike_s;
    logic [ADDR_W-1:0]       dest_s, src_s;
    logic                    unused_payload_s;
    logic                    xfer_s, pkt_good_s, pkt_bad_s;
    logic [CNT_W-1:0]        sel_cnt_s;
    logic                    start_run_s;
    logic                    hs_s, last_hs_s;
    logic [CNT_W-1:0]        cand_s;
    logic                    row_rdy_s;
    logic [NUM_PE-1:0]       cand_row_s;

    // Packet field decode; payload bits between src and spike carry nothing
    assign pkt_type_s       = bus.pkt_data[PKT_W-1];
    assign dest_s           = bus.pkt_data[PKT_W-2 -: ADDR_W];
    assign src_s            = bus.pkt_data[PKT_W-2-ADDR_W -: ADDR_W];
    assign spike_s          = bus.pkt_data[0];
    assign unused_payload_s = ^bus.pkt_data[PKT_W-2-2*ADDR_W:1];

    assign xfer_s      = bus.pkt_valid & pkt_ready_r;
    assign start_run_s = (state_r == S_IDLE) & start;

    // Fetch the write counter of the PE named in the packet source field
    always_comb begin
        sel_cnt_s = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            sel_cnt_s = (src_s == ADDR_W'(p)) ? wr_cnt_r[p] : sel_cnt_s;
        end
    end

    assign pkt_good_s = xfer_s & ~pkt_type_s
                      & (dest_s == ADDR_W'(MY_ADDR))
                      & (src_s < ADDR_W'(NUM_PE))
                      & (sel_cnt_s < CNT_W'(OUT_PER_PE));
    assign pkt_bad_s  = xfer_s & ~pkt_good_s;

    // Next buffer contents and write counters (start clears the counters)
    always_comb begin
        cnt_nxt_s = wr_cnt_r;
        buf_nxt_s = spike_buf_r;
        if (start_run_s) begin
            for (int p = 0; p < NUM_PE; p++) begin
                cnt_nxt_s[p] = '0;
            end
        end else if (pkt_good_s) begin
            for (int p = 0; p < NUM_PE; p++) begin
                if (src_s == ADDR_W'(p)) begin
                    cnt_nxt_s[p] = wr_cnt_r[p] + CNT_W'(1);
                    for (int k = 0; k < OUT_PER_PE; k++) begin
                        buf_nxt_s[p][k] = (wr_cnt_r[p] == CNT_W'(k)) ? spike_s
                                                                     : spike_buf_r[p][k];
                    end
                end else begin
                    cnt_nxt_s[p] = wr_cnt_r[p];
                end
            end
        end else begin
            cnt_nxt_s = wr_cnt_r;
        end
    end

    // Sticky drop flag and saturating drop counter
    always_comb begin
        err_drop_nxt_s   = err_drop_r;
        drop_count_nxt_s = drop_count_r;
        if (start_run_s) begin
            err_drop_nxt_s   = 1'b0;
            drop_count_nxt_s = 8'd0;
        end else if (pkt_bad_s) begin
            err_drop_nxt_s   = 1'b1;
            drop_count_nxt_s = (drop_count_r == 8'd255) ? drop_count_r
                                                        : drop_count_r + 8'd1;
        end else begin
            err_drop_nxt_s   = err_drop_r;
            drop_count_nxt_s = drop_count_r;
        end
    end

    // The row to present next is rd_idx, or rd_idx+1 when the current row
    // is being taken this cycle.
    assign hs_s      = out_valid_r & bus.out_ready;
    assign last_hs_s = hs_s & (rd_idx_r == IDX_W'(OUT_PER_PE - 1));
    assign cand_s    = hs_s ? (CNT_W'(rd_idx_r) + CNT_W'(1)) : CNT_W'(rd_idx_r);

    // Completeness and contents of the candidate row, including this cycle's write
    always_comb begin
        row_rdy_s  = 1'b1;
        cand_row_s = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            row_rdy_s = row_rdy_s & (cnt_nxt_s[p] > cand_s);
            for (int k = 0; k < OUT_PER_PE; k++) begin
                cand_row_s[p] = (cand_s == CNT_W'(k)) ? buf_nxt_s[p][k] : cand_row_s[p];
            end
        end
    end

    // Output row register and read index sequencing
    always_comb begin
        out_valid_nxt_s = out_valid_r;
        out_row_nxt_s   = out_row_r;
        out_idx_nxt_s   = out_idx_r;
        rd_idx_nxt_s    = rd_idx_r;
        case (state_r)
            S_IDLE: begin
                out_valid_nxt_s = 1'b0;
                if (start) begin
                    rd_idx_nxt_s  = '0;
                    out_idx_nxt_s = '0;
                    out_row_nxt_s = '0;
                end else begin
                    rd_idx_nxt_s  = rd_idx_r;
                end
            end
            S_COLLECT: begin
                if (last_hs_s) begin
                    out_valid_nxt_s = 1'b0;
                end else if (!out_valid_r || hs_s) begin
                    rd_idx_nxt_s    = cand_s[IDX_W-1:0];
                    out_valid_nxt_s = row_rdy_s;
                    out_row_nxt_s   = row_rdy_s ? cand_row_s : '0;
                    out_idx_nxt_s   = cand_s[IDX_W-1:0];
                end else begin
                    out_valid_nxt_s = 1'b1;
                end
            end
            S_DONE: begin
                out_valid_nxt_s = 1'b0;
            end
            default: begin
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM next-state: a run ends when the last row is taken
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_COLLECT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (last_hs_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_COLLECT;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered output flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PE; p++) begin
                spike_buf_r[p] <= '0;
                wr_cnt_r[p]    <= '0;
            end
            rd_idx_r     <= '0;
            out_valid_r  <= 1'b0;
            out_row_r    <= '0;
            out_idx_r    <= '0;
            err_drop_r   <= 1'b0;
            drop_count_r <= 8'd0;
            pkt_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            spike_buf_r  <= buf_nxt_s;
            wr_cnt_r     <= cnt_nxt_s;
            rd_idx_r     <= rd_idx_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            out_row_r    <= out_row_nxt_s;
            out_idx_r    <= out_idx_nxt_s;
            err_drop_r   <= err_drop_nxt_s;
            drop_count_r <= drop_count_nxt_s;
            pkt_ready_r  <= (state_nxt_s == S_COLLECT);
            busy_r       <= (state_nxt_s == S_COLLECT);
            done_r       <= (state_nxt_s == S_DONE);
        end
    end

    assign bus.pkt_ready = pkt_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_row   = out_row_r;
    assign bus.out_idx   = out_idx_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err_drop      = err_drop_r;
    assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_spike_collector.sv
// Randomised scoreboard bench for spike_collector. A per-PE reference model
// predicts rows; a monitor compares every presented row against the queue.
module tb_spike_collector;
    localparam int NUM_PE = 5;
    localparam int OUT    = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, err_drop;
    logic [7:0] drop_count;

    spike_collector_if #(.PKT_W(33), .NUM_PE(NUM_PE), .IDX_W(4)) bus ();

    spike_collector #(.NUM_PE(NUM_PE), .OUT_PER_PE(OUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .busy(busy), .done(done), .err_drop(err_drop), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: per-PE spike lists and expected rows
    typedef struct { int idx; logic [NUM_PE-1:0] row; } row_t;
    row_t exp_q[$];
    int   m_cnt [NUM_PE];
    bit   m_spk [NUM_PE][OUT];
    int   m_next_row;
    int   m_drops;
    bit   m_err;

    int rdy_mode = 0;
    bit manual_rdy = 1'b0;
    int done_total = 0;
    int done_cycle = 0;
    int first_hs_cycle = 0;
    int last_hs_cycle = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_start();
        for (int p = 0; p < NUM_PE; p++) m_cnt[p] = 0;
        m_next_row = 0;
        m_drops = 0;
        m_err = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_pkt(bit ty, int dst, int src, bit spk);
        bit all;
        row_t r;
        if (ty == 1'b0 && dst == 13 && src < NUM_PE && m_cnt[src] < OUT) begin
            m_spk[src][m_cnt[src]] = spk;
            m_cnt[src]++;
        end else begin
            m_drops++;
            m_err = 1'b1;
        end
        while (m_next_row < OUT) begin
            all = 1'b1;
            for (int p = 0; p < NUM_PE; p++) if (m_cnt[p] <= m_next_row) all = 1'b0;
            if (!all) break;
            r.idx = m_next_row;
            for (int p = 0; p < NUM_PE; p++) r.row[p] = m_spk[p][m_next_row];
            exp_q.push_back(r);
            m_next_row++;
        end
    endfunction

    function automatic int sat_drops();
        return (m_drops > 255) ? 255 : m_drops;
    endfunction

    function automatic logic [32:0] mk_pkt(bit ty, logic [3:0] dst, logic [3:0] src, bit spk);
        return {ty, dst, src, 23'($urandom), spk};
    endfunction

    // out_ready driver
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: bus.out_ready = 1'b0;
                1: bus.out_ready = 1'b1;
                2: bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = manual_rdy;
            endcase
        end
    end

    // monitor: compare each presented row with the head of the scoreboard
    initial begin
        row_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_row: got idx %0d row %b, expected none",
                                 bus.out_idx, bus.out_row);
                    end else begin
                        e = exp_q[0];
                        check("row_idx", 32'(bus.out_idx), 32'(e.idx));
                        check("row_bits", 32'(bus.out_row), 32'(e.row));
                        if (bus.out_ready) begin
                            void'(exp_q.pop_front());
                            if (e.idx == 0) first_hs_cycle = cyc;
                            if (e.idx == OUT - 1) last_hs_cycle = cyc;
                        end
                    end
                end
                if (done) begin
                    done_total++;
                    done_cycle = cyc;
                end
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(bit ty, logic [3:0] dst, logic [3:0] src, bit spk);
        bus.pkt_data  = mk_pkt(ty, dst, src, spk);
        bus.pkt_valid = 1'b1;
        model_pkt(ty, int'(dst), int'(src), spk);
        @(negedge clk);
        check("pkt_ready", 32'(bus.pkt_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.pkt_valid = 1'b0;
    endtask

    task automatic send_bad();
        case ($urandom_range(0, 2))
            0: send(1'b1, 4'd13, 4'($urandom_range(0, 4)), 1'($urandom));
            1: send(1'b0, 4'($urandom_range(0, 12)), 4'($urandom_range(0, 4)), 1'($urandom));
            default: send(1'b0, 4'd13, 4'($urandom_range(5, 15)), 1'($urandom));
        endcase
    endtask

    task automatic do_start();
        start = 1'b1;
        model_start();
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_busy", 32'(busy), 32'd1);
        check("start_drop_count", 32'(drop_count), 32'd0);
        check("start_err_drop", 32'(err_drop), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_rr(bit rnd);
        for (int k = 0; k < OUT; k++)
            for (int p = 0; p < NUM_PE; p++)
                send(1'b0, 4'd13, 4'(p), rnd ? 1'($urandom) : 1'((p + k) & 1));
    endtask

    task automatic wait_done(int budget);
        int base = done_total;
        int n = 0;
        while (done_total == base && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        #1;
        check("done_count", 32'(done_total - base), 32'd1);
        check("done_after_last_row", 32'(done_cycle), 32'(last_hs_cycle + 1));
        check("rows_left", 32'(exp_q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_pkt_ready", 32'(bus.pkt_ready), 32'd0);
        check("err_drop", 32'(err_drop), 32'(m_err));
        check("drop_count", 32'(drop_count), 32'(sat_drops()));
        @(posedge clk);
        #1;
    endtask

    task automatic random_run();
        int order[$];
        int j, tmp;
        do_start();
        rdy_mode = 2;
        for (int p = 0; p < NUM_PE; p++)
            for (int k = 0; k < OUT; k++) order.push_back(p);
        for (int i = order.size() - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        foreach (order[i]) begin
            if ($urandom_range(0, 9) == 0) send_bad();
            if ($urandom_range(0, 3) == 0) idle(1);
            send(1'b0, 4'd13, 4'(order[i]), 1'($urandom));
        end
        wait_done(400);
    endtask

    initial begin
        bus.pkt_valid = 1'b0;
        bus.pkt_data  = '0;
        model_start();

        // reset state
        #3;
        check("rst_pkt_ready", 32'(bus.pkt_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_row", 32'(bus.out_row), 32'd0);
        check("rst_out_idx", 32'(bus.out_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_drop", 32'(err_drop), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // round-robin checkerboard
        do_start();
        rdy_mode = 1;
        send_rr(1'b0);
        wait_done(200);

        // PE0 runs ahead; the last PE's first packet completes row 0
        do_start();
        rdy_mode = 1;
        for (int k = 0; k < OUT; k++) send(1'b0, 4'd13, 4'd0, 1'b1);
        for (int p = 1; p < NUM_PE - 1; p++) send(1'b0, 4'd13, 4'(p), 1'b0);
        @(negedge clk);
        check("no_row_yet", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.pkt_data  = mk_pkt(1'b0, 4'd13, 4'd4, 1'b1);
        bus.pkt_valid = 1'b1;
        model_pkt(1'b0, 13, 4, 1'b1);
        @(negedge clk);
        check("row0_same_cycle", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.pkt_valid = 1'b0;
        @(negedge clk);
        check("row0_latency", 32'(bus.out_valid), 32'd1);
        check("row0_latency_idx", 32'(bus.out_idx), 32'd0);
        @(posedge clk);
        #1;
        for (int k = 1; k < OUT; k++)
            for (int p = 1; p < NUM_PE; p++) send(1'b0, 4'd13, 4'(p), 1'($urandom));
        wait_done(200);

        // consumer stalled during collection, then drains back-to-back
        rdy_mode = 0;
        do_start();
        send_rr(1'b1);
        idle(3);
        @(negedge clk);
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_idx", 32'(bus.out_idx), 32'd0);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        wait_done(100);
        check("back_to_back", 32'(last_hs_cycle - first_hs_cycle), 32'(OUT - 1));

        // dropped packets: bad type, bad dest, bad src, 11th from PE2
        do_start();
        rdy_mode = 2;
        for (int k = 0; k < OUT; k++) begin
            for (int p = 0; p < NUM_PE; p++) begin
                send(1'b0, 4'd13, 4'(p), 1'($urandom));
                if (k == OUT - 1 && p == 2) send(1'b0, 4'd13, 4'd2, 1'b1);
            end
            if (k == 3) send(1'b1, 4'd13, 4'd1, 1'b1);
            if (k == 5) send(1'b0, 4'd12, 4'd1, 1'b1);
            if (k == 7) send(1'b0, 4'd13, 4'd7, 1'b1);
        end
        wait_done(300);
        check("four_drops", 32'(drop_count), 32'd4);

        // reset while row 3 is presented
        rdy_mode = 3;
        manual_rdy = 1'b0;
        do_start();
        send_rr(1'b1);
        idle(2);
        manual_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        manual_rdy = 1'b0;
        @(negedge clk);
        check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        check("pre_reset_idx", 32'(bus.out_idx), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_idx", 32'(bus.out_idx), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        check("no_row_after_reset", 32'(bus.out_valid), 32'd0);
        rdy_mode = 1;
        do_start();
        send_rr(1'b0);
        wait_done(200);

        // drop counter saturation, cleared by the next start
        do_start();
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) send_bad();
        @(negedge clk);
        check("sat_drop_count", 32'(drop_count), 32'd255);
        check("sat_err_drop", 32'(err_drop), 32'd1);
        @(posedge clk);
        #1;
        send_rr(1'b1);
        wait_done(200);
        do_start();
        send_rr(1'b1);
        wait_done(200);

        // randomised runs
        for (int r = 0; r < 3; r++) random_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
